// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode constants, fetch state encoding and reset defaults
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select: jump, then taken branch, then sequential
module next_pc_calc (
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        jump,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  output logic [31:0] next_pc
);

  logic        taken;
  logic [31:0] branch_off;
  logic        unused_opcode;

  assign taken         = (branch & zero) | (bne & ~zero);
  assign branch_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign unused_opcode = ^instr[31:26];

  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + branch_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner: fetches over req/ack, holds the instruction until the core retires it
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch,
  input  logic        bne,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret
);

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_q, instr_q, instret_q, next_pc;
  logic         fetch_done, retire;

  assign fetch_done = (state == FETCH_REQ) && imem_ack;
  assign retire     = (state == FETCH_HOLD) && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_IDLE: state_nxt = FETCH_REQ;
      FETCH_REQ:  if (imem_ack) state_nxt = FETCH_HOLD;
      FETCH_HOLD: if (instr_ready) state_nxt = FETCH_REQ;
      default:    state_nxt = FETCH_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = (state == FETCH_REQ);
    instr_valid = (state == FETCH_HOLD);
  end

  // pc only moves on retire, so imem_addr stays stable for the whole request
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC_ALIGNED;
      instr_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      if (fetch_done) begin
        instr_q <= imem_rdata;
      end
      if (retire) begin
        pc_q      <= next_pc;
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .jump     (jump),
    .branch   (branch),
    .bne      (bne),
    .zero     (zero),
    .next_pc  (next_pc)
  );

  assign pc_plus4  = pc_q + 32'd4;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign instret   = instret_q;

endmodule
